// File: rtl/mux_2_to_1.sv
// Two-input selector with a combinational output, a registered copy of the
// selected data, and select-change debug outputs (pulse + saturating counter).
module mux_2_to_1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] data_in,
    input  logic               sel,
    output logic [WIDTH-1:0]   mux_out,
    output logic [WIDTH-1:0]   mux_out_q,
    output logic               sel_changed,
    output logic [CNT_W-1:0]   switch_cnt
);

    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             sel_q;
    logic             sel_diff;

    assign in_a     = data_in[WIDTH-1:0];
    assign in_b     = data_in[2*WIDTH-1:WIDTH];
    assign sel_diff = (sel != sel_q);

    // NOTE: every path assigns mux_out, so no latch is inferred; an unknown
    // select deliberately yields X rather than silently favouring one input.
    always_comb begin
        case (sel)
            1'b0:    mux_out = in_a;
            1'b1:    mux_out = in_b;
            default: mux_out = 'x;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling the values
    // present before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_out_q   <= '0;
            sel_q       <= 1'b0;
            sel_changed <= 1'b0;
            switch_cnt  <= '0;
        end else begin
            mux_out_q   <= mux_out;
            sel_q       <= sel;
            sel_changed <= sel_diff;
            // Counter sticks at all-ones so a long run never reads as "few switches".
            if (sel_diff && (switch_cnt != '1)) begin
                switch_cnt <= switch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_2_to_1.sv
// Self-checking bench for mux_2_to_1: three instances (1-bit, 1-bit with a
// 2-bit counter, 8-bit) compared against a transition-counting reference model.
module tb_mux_2_to_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       mo1, mq1, ch1;
    logic [7:0] cnt1;
    logic       mos, mqs, chs;
    logic [1:0] cnts;
    logic [7:0] mo8, mq8;
    logic       ch8;
    logic [7:0] cnt8;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: select history as a plain transition count.
    logic       m_sel;
    int         m_trans;
    logic       e_q1;
    logic [7:0] e_q8;
    logic       e_ch;

    always #5 clk = ~clk;

    mux_2_to_1 #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .data_in({b1, a1}), .sel(sel),
        .mux_out(mo1), .mux_out_q(mq1), .sel_changed(ch1), .switch_cnt(cnt1)
    );

    mux_2_to_1 #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .data_in({b1, a1}), .sel(sel),
        .mux_out(mos), .mux_out_q(mqs), .sel_changed(chs), .switch_cnt(cnts)
    );

    mux_2_to_1 #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .data_in({b8, a8}), .sel(sel),
        .mux_out(mo8), .mux_out_q(mq8), .sel_changed(ch8), .switch_cnt(cnt8)
    );

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic reset_model();
        m_sel   = 1'b0;
        m_trans = 0;
        e_q1    = 1'b0;
        e_q8    = 8'h00;
        e_ch    = 1'b0;
    endtask

    // Advance the model by one edge, then land 1 ns after the rising edge.
    task automatic tick();
        e_ch = (sel != m_sel);
        if (e_ch) m_trans++;
        m_sel = sel;
        e_q1  = sel ? b1 : a1;
        e_q8  = sel ? b8 : a8;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_reset();
        // NOTE: bench drives use blocking assignments, away from the clock edge.
        rst_n = 1'b0;
        sel = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        @(posedge clk);
        #1;
        n_total++;
        if ({mq1, ch1, cnt1, mqs, chs, cnts, mq8, ch8, cnt8} !== '0)
            $display("FAIL reset_state got %h expected 0",
                     {mq1, ch1, cnt1, mqs, chs, cnts, mq8, ch8, cnt8});
        else n_pass++;
        a1 = 1'b1;
        #1;
        n_total++;
        if (mo1 !== 1'b1) $display("FAIL reset_comb got %b expected 1", mo1);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_truth_table(input logic s);
        logic [2:0] tab [4];   // {a, b, expected}
        if (s == 1'b0) tab = '{3'b000, 3'b101, 3'b111, 3'b010};
        else           tab = '{3'b100, 3'b000, 3'b011, 3'b100};
        for (int i = 0; i < 4; i++) begin
            sel = s;
            a1  = tab[i][2];
            b1  = tab[i][1];
            #1;
            n_total++;
            if (mo1 !== tab[i][0])
                $display("FAIL truth_sel%0b_%0d got %b expected %b", s, i, mo1, tab[i][0]);
            else n_pass++;
            tick();
            n_total++;
            if (mq1 !== e_q1)
                $display("FAIL truth_q_sel%0b_%0d got %b expected %b", s, i, mq1, e_q1);
            else n_pass++;
        end
    endtask

    task automatic test_registered();
        apply_reset();
        a1 = 1'b1; b1 = 1'b0; sel = 1'b0;
        tick();
        n_total++;
        if ({mq1, ch1, cnt1} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL reg_load got %h expected %h", {mq1, ch1, cnt1}, {1'b1, 1'b0, 8'd0});
        else n_pass++;
        sel = 1'b1;
        tick();
        n_total++;
        if ({mq1, ch1, cnt1} !== {e_q1, e_ch, 8'(sat(m_trans, 8))} || cnt1 !== 8'd1)
            $display("FAIL reg_switch got %h expected %h", {mq1, ch1, cnt1},
                     {e_q1, e_ch, 8'(sat(m_trans, 8))});
        else n_pass++;
        tick();
        n_total++;
        if (ch1 !== 1'b0) $display("FAIL reg_pulse_width got %b expected 0", ch1);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [2:0] seq;
        seq = 3'b101;
        apply_reset();
        a1 = 1'b0; b1 = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            sel = seq[i];
            tick();
        end
        n_total++;
        if ({mq1, cnt1} !== {1'b1, 8'd3})
            $display("FAIL arst_setup got %h expected %h", {mq1, cnt1}, {1'b1, 8'd3});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({mq1, ch1, cnt1, mqs, chs, cnts, mq8, ch8, cnt8} !== '0)
            $display("FAIL arst_clear got %h expected 0",
                     {mq1, ch1, cnt1, mqs, chs, cnts, mq8, ch8, cnt8});
        else n_pass++;
        a1 = 1'b1; sel = 1'b0;
        #1;
        n_total++;
        if (mo1 !== 1'b1) $display("FAIL arst_comb0 got %b expected 1", mo1);
        else n_pass++;
        b1 = 1'b0; sel = 1'b1;
        #1;
        n_total++;
        if (mo1 !== 1'b0) $display("FAIL arst_comb1 got %b expected 0", mo1);
        else n_pass++;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_saturation();
        int want [6];
        want = '{1, 2, 3, 3, 3, 3};
        apply_reset();
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel = ~sel;
            tick();
            n_total++;
            if (cnts !== 2'(sat(m_trans, 2)) || cnts !== 2'(want[i]))
                $display("FAIL sat_cnt_%0d got %0d expected %0d", i, cnts, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_width8();
        a8 = 8'h3C; b8 = 8'hA5; sel = 1'b0;
        #1;
        n_total++;
        if (mo8 !== 8'h3C) $display("FAIL w8_comb0 got %h expected 3c", mo8);
        else n_pass++;
        tick();
        n_total++;
        if (mq8 !== 8'h3C) $display("FAIL w8_q0 got %h expected 3c", mq8);
        else n_pass++;
        sel = 1'b1;
        #1;
        n_total++;
        if (mo8 !== 8'hA5) $display("FAIL w8_comb1 got %h expected a5", mo8);
        else n_pass++;
        tick();
        n_total++;
        if (mq8 !== 8'hA5) $display("FAIL w8_q1 got %h expected a5", mq8);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) apply_reset();
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            sel = ($urandom_range(0, 3) != 0) ? ~sel : sel;
            #1;
            n_total++;
            if ({mo1, mos, mo8} !== {sel ? b1 : a1, sel ? b1 : a1, sel ? b8 : a8})
                $display("FAIL rand_comb_%0d got %h expected %h", i, {mo1, mos, mo8},
                         {sel ? b1 : a1, sel ? b1 : a1, sel ? b8 : a8});
            else n_pass++;
            tick();
            n_total++;
            if ({mq1, ch1, cnt1} !== {e_q1, e_ch, 8'(sat(m_trans, 8))})
                $display("FAIL rand_w1_%0d got %h expected %h", i, {mq1, ch1, cnt1},
                         {e_q1, e_ch, 8'(sat(m_trans, 8))});
            else n_pass++;
            n_total++;
            if ({mqs, chs, cnts} !== {e_q1, e_ch, 2'(sat(m_trans, 2))})
                $display("FAIL rand_sat_%0d got %h expected %h", i, {mqs, chs, cnts},
                         {e_q1, e_ch, 2'(sat(m_trans, 2))});
            else n_pass++;
            n_total++;
            if ({mq8, ch8, cnt8} !== {e_q8, e_ch, 8'(sat(m_trans, 8))})
                $display("FAIL rand_w8_%0d got %h expected %h", i, {mq8, ch8, cnt8},
                         {e_q8, e_ch, 8'(sat(m_trans, 8))});
            else n_pass++;
        end
    endtask

    initial begin
        reset_model();
        test_reset();
        test_truth_table(1'b0);
        test_truth_table(1'b1);
        test_registered();
        test_async_reset();
        test_saturation();
        test_width8();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_2_to_1.md
# mux_2_to_1

Two-input, one-output selector with a combinational output and a registered copy of the same result. Input 0 (`data_in[0]` for WIDTH=1) is forwarded when `sel`=0 and input 1 when `sel`=1. A select-change pulse and a saturating switch counter support debug and coverage. The block is a leaf primitive used wherever a datapath steers one of two sources onto a shared line.

## Interface
- `WIDTH`, default 1: bit width of each data input and of the output.
- `CNT_W`, default 8: width of the select-switch counter.
- `clk` input 1: single clock; all registers update on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `data_in` input 2*WIDTH: packed inputs; `data_in[WIDTH-1:0]` is input 0 ("a"), `data_in[2*WIDTH-1:WIDTH]` is input 1 ("b"). Callers connect `{b, a}`.
- `sel` input 1: 0 selects input 0, 1 selects input 1.
- `mux_out` output WIDTH: combinational selected data.
- `mux_out_q` output WIDTH: registered selected data.
- `sel_changed` output 1: one-cycle pulse when the registered select differs from the previous registered select.
- `switch_cnt` output CNT_W: count of select transitions, saturating.

One clock. Reset is asynchronous and active-low.

## Operation
- The combinational path depends on `data_in` and `sel` only. It is independent of `clk` and `rst_n`.
  - `sel`=0: `mux_out` = input 0.
  - `sel`=1: `mux_out` = input 1.
  - `sel` X/Z: `mux_out` is X in simulation. No priority default applies.
- Registered path:
  - `mux_out_q` loads `mux_out` on every rising `clk`. There is no enable.
  - `sel_q` is an internal register that loads `sel` on every rising `clk`.
  - `sel_changed` = (`sel` sampled this edge) != `sel_q`. It is registered, so it asserts for exactly one cycle after each edge where a change is sampled.
  - `switch_cnt` increments by 1 on each edge where a change is sampled. It holds at all-ones once it saturates and never wraps.
- Reset (`rst_n`=0, asynchronous assert, takes effect immediately):
  - `mux_out_q`=0, `sel_q`=0, `sel_changed`=0, `switch_cnt`=0.
  - `mux_out` keeps following its inputs during reset.
- Reset release: the first edge after release compares `sel` against `sel_q`=0. Coming out of reset with `sel`=1 therefore counts as one switch.
- Reset mid-operation: all registered state clears at once. Nothing is retained across reset.
- Data width rules: no arithmetic on data. `switch_cnt` is unsigned CNT_W bits.

## Timing
- `mux_out`: zero-cycle, purely combinational latency from `data_in`/`sel`.
- `mux_out_q`: 1-cycle latency. It equals the `mux_out` value present just before the rising edge.
- `sel_changed`/`switch_cnt`: updated on the edge where the change is sampled and visible in the following cycle.
- No handshake and no back-pressure. A new input is accepted every cycle.
- Simultaneous change of `sel` and data: the output reflects the new `sel` applied to the new data. There is no glitch-suppression requirement on `mux_out`.

## Test plan
- Combinational truth table, `sel`=0, in the `rst_n`=1 idle state with 10 ns per step:
  - (a,b)=(0,0) -> 0
  - (1,0) -> 1
  - (1,1) -> 1
  - (0,1) -> 0
- Combinational truth table, `sel`=1:
  - (a,b)=(1,0) -> 0
  - (0,0) -> 0
  - (0,1) -> 1
  - (1,0) -> 0
- Registered path, WIDTH=1:
  - Apply a=1, b=0, `sel`=0 -> `mux_out_q`=1 one cycle later.
  - Set `sel`=1 -> `mux_out_q`=0 on the next cycle and `sel_changed` pulses high for 1 cycle.
  - `switch_cnt` goes 0->1.
- Async reset:
  - Drive `mux_out_q`=1 and `switch_cnt`=3.
  - Pull `rst_n` low between edges -> all registered outputs read 0 immediately.
  - `mux_out` still tracks its inputs during reset.
- Saturation: CNT_W=2, toggle `sel` every cycle for 6 cycles -> `switch_cnt` goes 1,2,3,3,3,3.
- WIDTH=8: `data_in`={8'hA5, 8'h3C}.
  - `sel`=0 -> `mux_out`=8'h3C.
  - `sel`=1 -> `mux_out`=8'hA5.
  - `mux_out_q` follows each value with 1 cycle of latency.
